// File: rtl/freq_meas_ctrl.sv
// freq_meas_ctrl: measurement sequencer for the equal-precision frequency meter.
// Opens a gate window aligned to test edges, drives the shared counter clear/enable,
// kicks the divider, publishes freq with a one-cycle freq_vld, and flags loss of signal.
// Optional build macro FREQ_SINGLE_SHOT_EN: adds meas_start and parks in HOLD between
// measurements (and out of reset) instead of free-running.
// Latency: test_edge -> gate_en 1 cycle; div_done -> freq/freq_vld 1 cycle. No backpressure.

module freq_meas_ctrl #(
  parameter int GATE_CYC    = 50_000_000,
  parameter int TIMEOUT_CYC = 100_000_000,
  parameter int GAP_CYC     = 12_500_000,
  parameter int FREQ_W      = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              test_edge,
`ifdef FREQ_SINGLE_SHOT_EN
  input  logic              meas_start,
`endif
  output logic              cnt_clr,
  output logic              gate_en,
  output logic              div_start,
  input  logic              div_done,
  input  logic [FREQ_W-1:0] div_result,
  output logic [FREQ_W-1:0] freq,
  output logic              freq_vld,
  output logic              no_sig,
  output logic              busy
);

  // One timer serves every timed state, so size it for the longest interval.
  localparam int MAX_GT  = (GATE_CYC > TIMEOUT_CYC) ? GATE_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_GT > GAP_CYC) ? MAX_GT : GAP_CYC;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;

  localparam logic [TMR_W-1:0] GATE_LAST = TMR_W'(GATE_CYC - 1);
  localparam logic [TMR_W-1:0] TOUT_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_GATE,
    S_CLOSE,
    S_CALC,
    S_TOUT,
    S_PUB,
    S_GAP,
    S_HOLD
  } state_t;

`ifdef FREQ_SINGLE_SHOT_EN
  localparam state_t RST_STATE = S_HOLD;
  localparam state_t GAP_EXIT  = S_HOLD;
`else
  localparam state_t RST_STATE = S_IDLE;
  localparam state_t GAP_EXIT  = S_IDLE;
`endif

  state_t           state;
  logic [TMR_W-1:0] timer;

  // Sequencer: state, timer and every output are registered here.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= RST_STATE;
      timer     <= '0;
      cnt_clr   <= 1'b0;
      gate_en   <= 1'b0;
      div_start <= 1'b0;
      freq      <= '0;
      freq_vld  <= 1'b0;
      no_sig    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for exactly one cycle below.
      cnt_clr   <= 1'b0;
      div_start <= 1'b0;
      freq_vld  <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt_clr <= 1'b1;
          timer   <= '0;
          busy    <= 1'b1;
          state   <= S_ARM;
        end

        // Gate only opens on a test edge so the window starts phase-aligned.
        S_ARM: begin
          if (test_edge) begin
            gate_en <= 1'b1;
            timer   <= '0;
            state   <= S_GATE;
          end else if (timer == TOUT_LAST) begin
            timer <= '0;
            state <= S_TOUT;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end

        // Minimum gate length; edges here are irrelevant.
        S_GATE: begin
          if (timer == GATE_LAST) begin
            timer <= '0;
            state <= S_CLOSE;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end

        // Stretch the gate to the next test edge so it spans whole test periods.
        S_CLOSE: begin
          if (test_edge) begin
            gate_en   <= 1'b0;
            div_start <= 1'b1;
            timer     <= '0;
            state     <= S_CALC;
          end else if (timer == TOUT_LAST) begin
            gate_en <= 1'b0;
            timer   <= '0;
            state   <= S_TOUT;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end

        // div_start is still high on the first CALC cycle; a done seen then is stale.
        S_CALC: begin
          if (!div_start && div_done) begin
            freq     <= div_result;
            no_sig   <= 1'b0;
            freq_vld <= 1'b1;
            state    <= S_PUB;
          end
        end

        S_TOUT: begin
          freq     <= '0;
          no_sig   <= 1'b1;
          freq_vld <= 1'b1;
          state    <= S_PUB;
        end

        S_PUB: begin
          busy  <= 1'b0;
          timer <= '0;
          state <= S_GAP;
        end

        // Pacing gap so the display has time to show each result.
        S_GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            state <= GAP_EXIT;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end

`ifdef FREQ_SINGLE_SHOT_EN
        S_HOLD: begin
          if (meas_start) begin
            state <= S_IDLE;
          end
        end
`endif

        default: begin
          timer <= '0;
          state <= RST_STATE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb_freq_meas_ctrl: randomized measurement scenarios against a timeline model.
// Each measurement is laid out as absolute cycle windows (arm, gate, close, calc, pub, gap)
// from which the expected value of every output on every cycle is filled in.

module tb_freq_meas_ctrl;

  localparam int GATE_CYC    = 100;
  localparam int TIMEOUT_CYC = 300;
  localparam int GAP_CYC     = 10;
  localparam int FREQ_W      = 32;
  localparam int N           = 8000;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              test_edge;
  logic              div_done;
  logic [FREQ_W-1:0] div_result;
  logic              cnt_clr;
  logic              gate_en;
  logic              div_start;
  logic [FREQ_W-1:0] freq;
  logic              freq_vld;
  logic              no_sig;
  logic              busy;
`ifdef FREQ_SINGLE_SHOT_EN
  logic              meas_start = 1'b0;
`endif

  freq_meas_ctrl #(
    .GATE_CYC   (GATE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GAP_CYC    (GAP_CYC),
    .FREQ_W     (FREQ_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .test_edge (test_edge),
`ifdef FREQ_SINGLE_SHOT_EN
    .meas_start(meas_start),
`endif
    .cnt_clr   (cnt_clr),
    .gate_en   (gate_en),
    .div_start (div_start),
    .div_done  (div_done),
    .div_result(div_result),
    .freq      (freq),
    .freq_vld  (freq_vld),
    .no_sig    (no_sig),
    .busy      (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Stimulus per cycle (sampled at posedge t).
  bit              rst_a [N];
  bit              edge_a[N];
  bit              done_a[N];
  bit [FREQ_W-1:0] res_a [N];

  // Expected outputs just after posedge t.
  bit              e_clr [N];
  bit              e_gate[N];
  bit              e_ds  [N];
  bit              e_vld [N];
  bit              e_busy[N];
  bit              e_ns  [N];
  bit [FREQ_W-1:0] e_freq[N];

  // Result updates, folded into e_freq/e_ns by a forward pass.
  bit              upd    [N];
  bit              upd_ns [N];
  bit [FREQ_W-1:0] upd_val[N];

  int cur;     // cycle on which the next measurement starts (IDLE)
  int end_t;
  int n_chk  = 0;
  int n_pass = 0;

  // Lay out one measurement starting at cur.
  // arm_d/close_d < 0 means no edge (timeout); gate_per > 0 gives periodic edges
  // inside the gate, otherwise random ones; rst_k >= 0 resets rst_k cycles into CALC.
  task automatic run_meas(input int arm_d, input int gate_per, input int close_d,
                          input bit early, input int jd, input bit [FREQ_W-1:0] res,
                          input int rst_k);
    int e, c, p, r;
    e_clr[cur] = 1'b1;
    if (arm_d < 0) begin
      p = cur + TIMEOUT_CYC + 1;
      upd[p] = 1'b1; upd_val[p] = '0; upd_ns[p] = 1'b1;
    end else begin
      e = cur + 1 + arm_d;
      edge_a[e] = 1'b1;
      for (int t = e + 1; t <= e + GATE_CYC; t++) begin
        if (gate_per > 0) edge_a[t] = ((t - e) % gate_per) == 0;
        else              edge_a[t] = ($urandom_range(0, 3) == 0);
      end
      if (close_d < 0) begin
        c = e + GATE_CYC + TIMEOUT_CYC;
        for (int t = e; t < c; t++) e_gate[t] = 1'b1;
        p = c + 1;
        upd[p] = 1'b1; upd_val[p] = '0; upd_ns[p] = 1'b1;
      end else begin
        c = e + GATE_CYC + 1 + close_d;
        edge_a[c] = 1'b1;
        for (int t = e; t < c; t++) e_gate[t] = 1'b1;
        e_ds[c] = 1'b1;
        if (early) begin
          done_a[c + 1] = 1'b1;
          res_a[c + 1]  = $urandom() | 32'h1;
        end
        if (rst_k >= 0) begin
          r = c + 1 + rst_k;
          for (int t = r; t < r + 3; t++) rst_a[t] = 1'b1;
          for (int t = cur; t < r; t++) e_busy[t] = 1'b1;
          cur = r + 3;
          return;
        end
        p = c + 1 + jd;
        done_a[p] = 1'b1; res_a[p] = res;
        upd[p] = 1'b1; upd_val[p] = res; upd_ns[p] = 1'b0;
      end
    end
    e_vld[p] = 1'b1;
    for (int t = cur; t <= p; t++) e_busy[t] = 1'b1;
    cur = p + 2 + GAP_CYC;
  endtask

  task automatic pin(input string name, input bit [FREQ_W-1:0] got, input bit [FREQ_W-1:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL model %s: got %0d required %0d", name, got, want);
  endtask

  task automatic compare(input int t);
    logic [FREQ_W+5:0] act, exp_v;
    act   = {cnt_clr, gate_en, div_start, freq_vld, no_sig, busy, freq};
    exp_v = {e_clr[t], e_gate[t], e_ds[t], e_vld[t], e_ns[t], e_busy[t], e_freq[t]};
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL cycle %0d {clr,gate,ds,vld,nosig,busy,freq}: actual %b %b %b %b %b %b %0d required %b %b %b %b %b %b %0d",
                  t, cnt_clr, gate_en, div_start, freq_vld, no_sig, busy, freq,
                  e_clr[t], e_gate[t], e_ds[t], e_vld[t], e_ns[t], e_busy[t], e_freq[t]);
  endtask

  initial begin
    bit [FREQ_W-1:0] f;
    bit              ns;
    for (int t = 0; t < 4; t++) rst_a[t] = 1'b1;
    cur = 4;

    // Directed sequence, then random measurements.
    run_meas(4, 10, 9, 1'b0, 3, 32'd5_000_000, -1);                    // edges every 10
    run_meas(-1, 0, 0, 1'b0, 1, '0, -1);                              // no edge: ARM timeout
    run_meas($urandom_range(0, 40), 0, -1, 1'b0, 1, '0, -1);          // CLOSE timeout
    run_meas($urandom_range(0, 40), 0, $urandom_range(0, 40), 1'b0,
             $urandom_range(1, 8), $urandom(), -1);                  // valid clears no_sig
    run_meas(-1, 0, 0, 1'b0, 1, '0, -1);
    run_meas(TIMEOUT_CYC - 1, 0, $urandom_range(0, 40), 1'b0,
             $urandom_range(1, 8), $urandom(), -1);                  // edge at ARM timer 299
    run_meas($urandom_range(0, 40), 0, $urandom_range(0, 40), 1'b1, 5, 32'd1234, -1);
    run_meas($urandom_range(0, 40), 0, TIMEOUT_CYC - 1, 1'b0,
             $urandom_range(1, 8), $urandom() | 32'h1, -1);          // edge at CLOSE timer 299
    run_meas($urandom_range(0, 40), 0, $urandom_range(0, 40), 1'b0, 1, '0,
             $urandom_range(1, 3));                                  // reset mid-CALC
    while (cur < N - 900) begin
      case ($urandom_range(0, 5))
        0: run_meas($urandom_range(0, 40), 0, $urandom_range(0, 40), 1'b0,
                    $urandom_range(1, 8), $urandom(), -1);
        1: run_meas(-1, 0, 0, 1'b0, 1, '0, -1);
        2: run_meas($urandom_range(0, 40), 0, -1, 1'b0, 1, '0, -1);
        3: run_meas($urandom_range(0, 40), 0, $urandom_range(0, 40), 1'b1,
                    $urandom_range(1, 8), $urandom(), -1);
        4: run_meas($urandom_range(0, 40), 0, $urandom_range(0, 40), 1'b0, 1, '0,
                    $urandom_range(1, 3));
        default: run_meas(TIMEOUT_CYC - 1, 0, $urandom_range(0, 40), 1'b0,
                          $urandom_range(1, 8), $urandom(), -1);
      endcase
    end
    end_t = cur;

    // freq/no_sig hold their last published value; reset clears them.
    f = '0; ns = 1'b0;
    for (int t = 0; t < N; t++) begin
      if (rst_a[t]) begin
        f = '0; ns = 1'b0;
      end else if (upd[t]) begin
        f = upd_val[t]; ns = upd_ns[t];
      end
      e_freq[t] = f;
      e_ns[t]   = ns;
    end

    // Hand-derived timeline of the first two measurements.
    pin("clr_first",    {31'd0, e_clr[4]},   1);
    pin("clr_once",     {31'd0, e_clr[5]},   0);
    pin("gate_pre",     {31'd0, e_gate[8]},  0);
    pin("gate_rise",    {31'd0, e_gate[9]},  1);
    pin("gate_hold",    {31'd0, e_gate[118]}, 1);
    pin("gate_fall",    {31'd0, e_gate[119]}, 0);
    pin("ds_pulse",     {31'd0, e_ds[119]},  1);
    pin("ds_once",      {31'd0, e_ds[120]},  0);
    pin("freq_pre",     e_freq[122],         0);
    pin("freq_5M",      e_freq[123],         5_000_000);
    pin("vld_5M",       {31'd0, e_vld[123]}, 1);
    pin("vld_once",     {31'd0, e_vld[124]}, 0);
    pin("busy_pub_end", {31'd0, e_busy[124]}, 0);
    pin("tout_nosig",   {31'd0, e_ns[436]},  1);
    pin("tout_nosig_pre", {31'd0, e_ns[435]}, 0);
    pin("tout_vld",     {31'd0, e_vld[436]}, 1);
    pin("restart_clr",  {31'd0, e_clr[448]}, 1);

    for (int t = 0; t < end_t; t++) begin
      sys_rst    = rst_a[t];
      test_edge  = edge_a[t];
      div_done   = done_a[t];
      div_result = res_a[t];
      @(posedge sys_clk);
      @(negedge sys_clk);
      compare(t);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
